serial_negate_ctrl: RTL
=======================

// Module: serial_negate_ctrl
// PURPOSE
//  Word-level sequencer for the bit-serial two's-complement FSM datapath.
//  Accepts a parallel W-bit word over valid/ready, streams it LSB-first through
//  one serial bit cell, reassembles the result and presents it over valid/ready.
//  Supports pass, negate and absolute-value modes, and flags overflow.
// PARAMETERS
//  W   8   data word width in bits (>=2)
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  reset      in   1   synchronous, active-high; all state cleared on posedge while high
//  in_valid   in   1   input word valid
//  in_ready   out  1   controller can accept a word (high only in IDLE)
//  in_data    in   W   operand, two's complement
//  in_mode    in   2   00 pass, 01 negate, 10 abs, 11 reserved (treated as pass)
//  out_valid  out  1   result valid (high only in DONE)
//  out_ready  in   1   downstream accepts result
//  out_data   out  W   result word
//  out_ovf    out  1   overflow: negate/abs applied to -2^(W-1)
//  busy       out  1   high in SHIFT or DONE
//  ser_bit    out  1   bit currently driven into the serial cell (debug)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1 on the first cycle after reset; out_valid=0; out_data=0;
//   out_ovf=0; busy=0; ser_bit=0; shift count=0; cell seen_one=0.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready at edge T: latch in_data into shift reg,
//   resolve op: negate if mode=01, or mode=10 and in_data[W-1]=1; else pass.
//   Clear cell seen_one and the count. Latch ovf = op_negate & (in_data==1<<(W-1)). Go to SHIFT.
//  SHIFT: exactly W cycles (edges T+1..T+W); each cycle one bit, LSB first.
//   Serial rule (negate): out_bit = in_bit ^ seen_one; seen_one |= in_bit.
//   Pass: out_bit = in_bit; seen_one unused.
//   Result bit shifts into the result reg MSB-side, so after W shifts bit i sits at out_data[i].
//   Count runs 0..W-1; wraps to 0 with transition to DONE at edge T+W.
//  DONE: out_valid=1 from cycle after edge T+W; out_data/out_ovf stable until handshake.
//   On out_valid&out_ready: go to IDLE next edge. Minimum word period W+2 cycles.
//  in_ready=0 in SHIFT/DONE; in_valid there is ignored; no input buffering.
//  out_data/out_ovf hold the last result after the handshake until the next DONE.
//  Reserved mode 11 behaves as pass with ovf=0.
//  Reset mid-SHIFT or mid-DONE: word discarded, no out_valid pulse, IDLE next cycle.
//  Reset has priority over any simultaneous handshake.
//  Width: all arithmetic modulo 2^W; -2^(W-1) negates to itself with ovf=1.
// STRUCTURE
//  Shared package (ser_neg_pkg): mode encodings MODE_PASS/MODE_NEG/MODE_ABS,
//   state encodings ST_IDLE/ST_SHIFT/ST_DONE (2-bit).
//  Count width $clog2(W).
//  Sub-module serial_negate_cell: 1-bit serial two's-complement cell
//   (clk, reset, clr, en, neg, x -> y) holding seen_one.
//  The controller owns the handshakes, shift/result regs, count and ovf.
// TESTING (W=8)
//  T1 negate: in 0x05, mode 01, out_ready=1 -> out 0xFB, ovf 0; out_valid first high 9 cycles after accept.
//  T2 edges: negate 0x00 -> 0x00, ovf 0; negate 0x80 -> 0x80, ovf 1; negate 0xFF -> 0x01.
//  T3 abs/pass: abs 0xF6 -> 0x0A; abs 0x7F -> 0x7F; abs 0x80 -> 0x80, ovf 1; pass 0xA5 -> 0xA5; mode 11 0x3C -> 0x3C.
//  T4 backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid/out_data held,
//   in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
//  T5 reset mid-word: assert reset 3 cycles into SHIFT -> out_valid never pulses,
//   in_ready=1 next cycle; a new negate of 0x01 -> 0xFF.
//  T6 back-to-back: continuous in_valid with 4 words, out_ready=1 -> results in order, period 10 cycles.

Source files
------------

// File: rtl/ser_neg_pkg.sv
// Shared encodings for the bit-serial negate controller: operating modes, FSM states and
// the per-word operation decode.
package ser_neg_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Abs negates only negative operands; reserved mode 11 falls through as pass.
  function automatic logic resolve_negate(input logic [1:0] mode, input logic sign);
    return (mode == MODE_NEG) || ((mode == MODE_ABS) && sign);
  endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// One-bit serial two's-complement cell: fed LSB-first, it copies bits up to and including
// the first one, then inverts every later bit.
module serial_negate_cell (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic neg,
  input  logic x,
  output logic y
);

  logic seen_one_q, seen_one_d;

  always_comb begin
    y = x;
    if (neg) begin
      y = x ^ seen_one_q;
    end
  end

  always_comb begin
    seen_one_d = seen_one_q;
    if (clr) begin
      seen_one_d = 1'b0;
    end else if (en && neg) begin
      seen_one_d = seen_one_q | x;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

endmodule

// File: rtl/serial_negate_ctrl.sv
// Word-level sequencer: accepts a word, streams it LSB-first through the serial cell,
// reassembles the result and offers it downstream with an overflow flag.
module serial_negate_ctrl
  import ser_neg_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         busy,
  output logic         ser_bit
);

  localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(W - 1);
  localparam logic [W-1:0] MinNeg = {1'b1, {(W - 1){1'b0}}};

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_ovf_q, out_ovf_d;

  logic accept;
  logic shift_en;
  logic cell_y;

  serial_negate_cell u_cell (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (shift_en),
    .neg   (neg_q),
    .x     (shift_q[0]),
    .y     (cell_y)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    ovf_pend_d = ovf_pend_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    accept     = 1'b0;
    shift_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          shift_d    = in_data;
          neg_d      = resolve_negate(in_mode, in_data[W-1]);
          ovf_pend_d = neg_d && (in_data == MinNeg);
          cnt_d      = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        shift_d  = shift_q >> 1;
        // Result enters at the MSB so bit i lands at position i after W shifts.
        acc_d    = {cell_y, acc_q[W-1:1]};
        if (cnt_q == CntMax) begin
          cnt_d      = '0;
          out_data_d = acc_d;
          out_ovf_d  = ovf_pend_q;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      ovf_pend_q <= ovf_pend_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    ser_bit   = (state_q == ST_SHIFT) && shift_q[0];
    out_data  = out_data_q;
    out_ovf   = out_ovf_q;
  end

endmodule
